// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Purpose:
//   Request/response front end for a pair of AXI-Stream divider IPs (one signed,
//   one unsigned). It takes one 32-bit divide or modulo request at a time and
//   registers the operands. It then hands them to the selected IP over two AXIS
//   channels, captures the 64-bit IP result and returns either the quotient or
//   the remainder. The operation can be cancelled with flush at any point. A
//   zero divisor can optionally skip the IP and return a fixed result.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op                     00 div_w, 01 mod_w, 10 div_wu, 11 mod_wu
//   req_src1/req_src2          dividend / divisor
//   flush                      cancel the in-flight operation
//   resp_valid/resp_ready      response handshake, resp_result = 32-bit result
//   busy                       controller not idle
//   div_dividend_tdata,
//   div_divisor_tdata          registered operands, shared by both IPs
//   {s,u}div_*_tvalid/tready   AXIS operand channels of the signed/unsigned IP
//   {s,u}div_dout_tdata/tvalid IP result: [63:32] quotient, [31:0] remainder
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter logic DIV_ZERO_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy,

    output logic [31:0] div_dividend_tdata,
    output logic [31:0] div_divisor_tdata,

    output logic        sdiv_dividend_tvalid,
    input  logic        sdiv_dividend_tready,
    output logic        sdiv_divisor_tvalid,
    input  logic        sdiv_divisor_tready,
    input  logic [63:0] sdiv_dout_tdata,
    input  logic        sdiv_dout_tvalid,

    output logic        udiv_dividend_tvalid,
    input  logic        udiv_dividend_tready,
    output logic        udiv_divisor_tvalid,
    input  logic        udiv_divisor_tready,
    input  logic [63:0] udiv_dout_tdata,
    input  logic        udiv_dout_tvalid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] result_q, result_d;
    // Operand-channel valids, common to both IPs; op_q[1] steers them.
    logic        dvd_vld_q, dvd_vld_d;
    logic        dvs_vld_q, dvs_vld_d;

    // Channel view of whichever IP the current op selects.
    logic        sel_dvd_ready;
    logic        sel_dvs_ready;
    logic        sel_dout_valid;
    logic [63:0] sel_dout_data;
    logic        dvd_hs;
    logic        dvs_hs;

    assign sel_dvd_ready  = op_q[1] ? udiv_dividend_tready : sdiv_dividend_tready;
    assign sel_dvs_ready  = op_q[1] ? udiv_divisor_tready  : sdiv_divisor_tready;
    assign sel_dout_valid = op_q[1] ? udiv_dout_tvalid     : sdiv_dout_tvalid;
    assign sel_dout_data  = op_q[1] ? udiv_dout_tdata      : sdiv_dout_tdata;

    assign dvd_hs = dvd_vld_q && sel_dvd_ready;
    assign dvs_hs = dvs_vld_q && sel_dvs_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            result_q   <= 32'd0;
            dvd_vld_q  <= 1'b0;
            dvs_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            dvd_vld_q  <= dvd_vld_d;
            dvs_vld_q  <= dvs_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        // A valid only ever falls after its own handshake, whatever the state
        // or flush is doing, so an IP never sees a withdrawn beat.
        dvd_vld_d  = dvd_vld_q && !dvd_hs;
        dvs_vld_d  = dvs_vld_q && !dvs_hs;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d       = req_op;
                    dividend_d = req_src1;
                    divisor_d  = req_src2;
                    if (DIV_ZERO_FAST && (req_src2 == 32'd0)) begin
                        // Quotient of all ones, remainder equal to the dividend.
                        result_d = req_op[0] ? req_src1 : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else begin
                        dvd_vld_d = 1'b1;
                        dvs_vld_d = 1'b1;
                        state_d   = SEND;
                    end
                end
            end

            SEND: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (!dvd_vld_d && !dvs_vld_d) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (sel_dout_valid) begin
                    if (flush) begin
                        // Result arrives while being cancelled: drop it.
                        state_d = IDLE;
                    end else begin
                        result_d = op_q[0] ? sel_dout_data[31:0] : sel_dout_data[63:32];
                        state_d  = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end

            DONE: begin
                resp_valid = !flush;
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // The IP cannot answer before both operands are taken, so only
                // look at dout once both channels are finished.
                if (!dvd_vld_q && !dvs_vld_q && sel_dout_valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE) && !flush;
    assign busy        = (state_q != IDLE);
    assign resp_result = result_q;

    assign div_dividend_tdata = dividend_q;
    assign div_divisor_tdata  = divisor_q;

    assign sdiv_dividend_tvalid = dvd_vld_q && !op_q[1];
    assign sdiv_divisor_tvalid  = dvs_vld_q && !op_q[1];
    assign udiv_dividend_tvalid = dvd_vld_q &&  op_q[1];
    assign udiv_divisor_tvalid  = dvs_vld_q &&  op_q[1];

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//
// Purpose: self-checking bench for div_ctrl. The bench plays both divider IPs,
// computes expected results with plain integer arithmetic and checks the
// controller's handshakes, flush behaviour, zero-divisor bypass and reset.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;
    logic [31:0] div_dividend_tdata;
    logic [31:0] div_divisor_tdata;
    logic        sdiv_dividend_tvalid, sdiv_dividend_tready;
    logic        sdiv_divisor_tvalid,  sdiv_divisor_tready;
    logic [63:0] sdiv_dout_tdata;
    logic        sdiv_dout_tvalid;
    logic        udiv_dividend_tvalid, udiv_dividend_tready;
    logic        udiv_divisor_tvalid,  udiv_divisor_tready;
    logic [63:0] udiv_dout_tdata;
    logic        udiv_dout_tvalid;

    int checks = 0;
    int errors = 0;

    div_ctrl #(.DIV_ZERO_FAST(1'b1)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_src1             (req_src1),
        .req_src2             (req_src2),
        .flush                (flush),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_result          (resp_result),
        .busy                 (busy),
        .div_dividend_tdata   (div_dividend_tdata),
        .div_divisor_tdata    (div_divisor_tdata),
        .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
        .sdiv_dividend_tready (sdiv_dividend_tready),
        .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
        .sdiv_divisor_tready  (sdiv_divisor_tready),
        .sdiv_dout_tdata      (sdiv_dout_tdata),
        .sdiv_dout_tvalid     (sdiv_dout_tvalid),
        .udiv_dividend_tvalid (udiv_dividend_tvalid),
        .udiv_dividend_tready (udiv_dividend_tready),
        .udiv_divisor_tvalid  (udiv_divisor_tvalid),
        .udiv_divisor_tready  (udiv_divisor_tready),
        .udiv_dout_tdata      (udiv_dout_tdata),
        .udiv_dout_tvalid     (udiv_dout_tvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the selected IP's inputs; the other IP gets random noise that the
    // controller must ignore.
    task automatic ip(input logic uns, input logic dr, input logic sr,
                      input logic dv, input logic [63:0] dd);
        logic [63:0] junk;
        junk = {$urandom, $urandom};
        if (uns) begin
            udiv_dividend_tready = dr; udiv_divisor_tready = sr;
            udiv_dout_tvalid = dv;     udiv_dout_tdata = dd;
            sdiv_dividend_tready = 1'($urandom_range(0, 1));
            sdiv_divisor_tready  = 1'($urandom_range(0, 1));
            sdiv_dout_tvalid     = 1'($urandom_range(0, 1));
            sdiv_dout_tdata      = junk;
        end else begin
            sdiv_dividend_tready = dr; sdiv_divisor_tready = sr;
            sdiv_dout_tvalid = dv;     sdiv_dout_tdata = dd;
            udiv_dividend_tready = 1'($urandom_range(0, 1));
            udiv_divisor_tready  = 1'($urandom_range(0, 1));
            udiv_dout_tvalid     = 1'($urandom_range(0, 1));
            udiv_dout_tdata      = junk;
        end
    endtask

    function automatic logic [3:0] all_tvalids();
        return {sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                udiv_dividend_tvalid, udiv_divisor_tvalid};
    endfunction

    // Reference: quotient/remainder of the requested operation.
    task automatic ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (op[1]) begin
            q = a / b; r = a % b;
        end else begin
            sa = a; sb = b;
            q = 32'(sa / sb); r = 32'(sa % sb);
        end
    endtask

    // Offer a request and complete its handshake.
    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        #1;
        chk("req_ready_idle", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        req_src1 = $urandom; req_src2 = $urandom; req_op = 2'($urandom_range(0, 3));
    endtask

    // Full transaction: dividend ready from cycle d1, divisor ready from cycle d2,
    // IP answers after lat idle cycles, consumer stalls rr cycles.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int d1, input int d2, input int lat, input int rr);
        logic [31:0] q, r, exp;
        logic        uns;
        int          last;
        uns = op[1];
        ref_div(op, a, b, q, r);
        exp = op[0] ? r : q;
        req(op, a, b);
        if (b == 32'd0) begin
            ip(uns, 1'b0, 1'b0, 1'b0, 64'd0);
            #1;
            chk("zero_no_tvalid", all_tvalids(), 4'b0000);
        end else begin
            last = (d1 > d2) ? d1 : d2;
            for (int c = 0; c <= last; c++) begin
                ip(uns, 1'(c >= d1), 1'(c >= d2), 1'b0, 64'd0);
                #1;
                chk("dividend_tvalid", uns ? udiv_dividend_tvalid : sdiv_dividend_tvalid, 1'(c <= d1));
                chk("divisor_tvalid",  uns ? udiv_divisor_tvalid  : sdiv_divisor_tvalid,  1'(c <= d2));
                chk("other_ip_tvalid", uns ? {sdiv_dividend_tvalid, sdiv_divisor_tvalid}
                                           : {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b00);
                if (c == 0) begin
                    chk("dividend_tdata", div_dividend_tdata, a);
                    chk("divisor_tdata",  div_divisor_tdata,  b);
                end
                chk("send_no_resp", resp_valid, 1'b0);
                step();
            end
            for (int l = 0; l < lat; l++) begin
                ip(uns, 1'b0, 1'b0, 1'b0, 64'd0);
                #1;
                chk("wait_tvalids", all_tvalids(), 4'b0000);
                chk("wait_no_resp", resp_valid, 1'b0);
                chk("wait_busy", busy, 1'b1);
                step();
            end
            ip(uns, 1'b0, 1'b0, 1'b1, {q, r});
            step();
        end
        for (int k = 0; k <= rr; k++) begin
            resp_ready = 1'(k == rr);
            // Stray IP output while DONE must not disturb the held result.
            ip(uns, 1'b0, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            #1;
            chk("resp_valid", resp_valid, 1'b1);
            chk("resp_result", resp_result, exp);
            chk("done_req_ready", req_ready, 1'b0);
            step();
        end
        resp_ready = 1'b0;
        ip(uns, 1'b0, 1'b0, 1'b0, 64'd0);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_resp_valid", resp_valid, 1'b0);
        $display("txn op=%0d src1=%h src2=%h result=%h expected=%h", op, a, b, resp_result, exp);
    endtask

    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_src1 = 32'd0; req_src2 = 32'd0;
        flush = 1'b0; resp_ready = 1'b0;
        ip(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        sdiv_dout_tvalid = 1'b0; udiv_dout_tvalid = 1'b0;
        #1;
        chk("rst_tvalids", all_tvalids(), 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_dividend", div_dividend_tdata, 32'd0);
        chk("rst_divisor", div_divisor_tdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Signed divide/modulo of a negative dividend.
        run_txn(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 0);
        run_txn(2'b01, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        // Dividend taken first cycle, divisor two cycles later.
        run_txn(2'b00, 32'd1000, 32'd7, 0, 2, 2, 1);
        // Held response for 5 cycles, handshake on the 6th.
        run_txn(2'b10, 32'd100, 32'd2, 1, 0, 3, 5);
        // Zero divisor bypass.
        run_txn(2'b10, 32'd100, 32'd0, 0, 0, 0, 0);
        run_txn(2'b11, 32'd100, 32'd0, 0, 0, 0, 2);

        // Flush in SEND with both readies low: valids held until handshake.
        req(2'b00, 32'd100, 32'd7);
        ip(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", req_ready, 1'b0);
        step();
        flush = 1'b0;
        chk("drain_tvalids_held", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 2'b11);
        chk("drain_busy", busy, 1'b1);
        step();
        chk("drain_tvalids_held2", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 2'b11);
        ip(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        step();
        chk("drain_dividend_done", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 2'b01);
        ip(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        step();
        chk("drain_divisor_done", all_tvalids(), 4'b0000);
        ip(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        step();
        chk("drain_no_resp", resp_valid, 1'b0);
        chk("drain_req_ready", req_ready, 1'b0);
        ip(1'b0, 1'b0, 1'b0, 1'b1, {32'd14, 32'd2});
        #1;
        chk("drain_dout_no_resp", resp_valid, 1'b0);
        step();
        ip(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        #1;
        chk("after_drain_req_ready", req_ready, 1'b1);
        chk("after_drain_resp", resp_valid, 1'b0);
        $display("txn flush-in-send drained");

        // Flush in WAIT together with dout: straight to IDLE.
        req(2'b10, 32'd50, 32'd5);
        ip(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
        step();
        ip(1'b1, 1'b0, 1'b0, 1'b1, {32'd10, 32'd0});
        flush = 1'b1;
        step();
        flush = 1'b0;
        ip(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        #1;
        chk("wait_flush_idle", busy, 1'b0);
        chk("wait_flush_resp", resp_valid, 1'b0);
        $display("txn flush-in-wait discarded");

        // Flush in DONE: response withdrawn, IDLE without handshake.
        req(2'b11, 32'd9, 32'd0);
        flush = 1'b1;
        #1;
        chk("done_flush_resp", resp_valid, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chk("done_flush_idle", busy, 1'b0);
        chk("done_flush_req_ready", req_ready, 1'b1);
        $display("txn flush-in-done dropped");

        // Asynchronous reset while in WAIT.
        req(2'b00, 32'd77, 32'd3);
        ip(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        step();
        chk("pre_reset_busy", busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_tvalids", all_tvalids(), 4'b0000);
        chk("areset_busy", busy, 1'b0);
        chk("areset_resp_valid", resp_valid, 1'b0);
        chk("areset_result", resp_result, 32'd0);
        chk("areset_dividend", div_dividend_tdata, 32'd0);
        #1;
        reset = 1'b0;
        ip(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        step();
        chk("post_reset_req_ready", req_ready, 1'b1);
        $display("txn async reset in wait");

        // Randomized transactions against the arithmetic reference.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 5) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 20));
            else                                rb = $urandom;
            if (!rop[1] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            run_txn(rop, ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
